pipe_stage: RTL and testbench

- Generic parametrised pipeline register between two CPU stages (IF/ID, ID/EX, ...), with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
- The skid buffer lets the upstream ready be fully registered, so it breaks the combinational stall path.
- Stage wrappers instantiate it with WIDTH = $bits of their params struct.

---
 rtl/pipe_stage_pkg.sv | 29 ++
 rtl/pipe_stage.sv | 100 ++++++++++
 tb/tb_pipe_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_pkg.sv
// Types shared by the pipeline register and the stage wrappers that
// pack their params structs into its payload vector.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // All-zero payload decodes as NOP in the ID decoder.
  localparam logic [63:0] PIPE_BUBBLE = 64'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_params_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [3:0]  aluOp;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic [20:0] imm;
  } id_ex_params_t;

endpackage

// File: rtl/pipe_stage.sv
// Pipeline register between two CPU stages with valid/ready handshake,
// synchronous flush and an optional 2-entry skid buffer.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned      WIDTH        = 64,
  parameter bit               SKID_EN      = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             consume;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  // Skid mode keeps in_ready a pure function of registered state, which
  // breaks the stall path from downstream back to upstream.
  generate
    if (SKID_EN) begin : gSkidReady
      assign in_ready = (state_q != TWO);
    end else begin : gCombReady
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VALUE;
      skid_d  = BUBBLE_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept && SKID_EN) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VALUE;
          end
        end
        TWO: begin
          if (consume) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VALUE;
          skid_d  = BUBBLE_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VALUE;
      skid_q  <= BUBBLE_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: one skid and one non-skid instance,
// each compared against a payload-queue model of the stage.
module tb_pipe_stage;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         flush;

  logic         sInValid, sOutReady;
  logic [W-1:0] sInData;
  logic         sInReady, sOutValid;
  logic [W-1:0] sOutData;
  logic [1:0]   sOcc;

  logic         nInValid, nOutReady;
  logic [W-1:0] nInData;
  logic         nInReady, nOutValid;
  logic [W-1:0] nOutData;
  logic [1:0]   nOcc;

  int checkCount = 0;
  int passCount  = 0;

  logic [W-1:0] sq[$];
  logic [W-1:0] nq[$];

  pipe_stage #(.WIDTH(W), .SKID_EN(1'b1), .BUBBLE_VALUE('0)) dutSkid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(sInValid), .in_ready(sInReady), .in_data(sInData),
    .out_valid(sOutValid), .out_ready(sOutReady), .out_data(sOutData),
    .occupancy(sOcc)
  );

  pipe_stage #(.WIDTH(W), .SKID_EN(1'b0), .BUBBLE_VALUE('0)) dutNoSkid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(nInValid), .in_ready(nInReady), .in_data(nInData),
    .out_valid(nOutValid), .out_ready(nOutReady), .out_data(nOutData),
    .occupancy(nOcc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare both instances against the queue model: a stage holding N
  // payloads shows the oldest one and is ready while it has room.
  task automatic checkAll(input string tag);
    logic [W-1:0] sHead, nHead;
    sHead = '0;
    nHead = '0;
    if (sq.size() != 0) sHead = sq[0];
    if (nq.size() != 0) nHead = nq[0];
    checkOutput({tag, " s_valid"}, 64'(sOutValid), 64'(sq.size() != 0));
    checkOutput({tag, " s_data"},  64'(sOutData),  64'(sHead));
    checkOutput({tag, " s_occ"},   64'(sOcc),      64'(sq.size()));
    checkOutput({tag, " s_ready"}, 64'(sInReady),  64'(sq.size() < 2));
    checkOutput({tag, " n_valid"}, 64'(nOutValid), 64'(nq.size() != 0));
    checkOutput({tag, " n_data"},  64'(nOutData),  64'(nHead));
    checkOutput({tag, " n_occ"},   64'(nOcc),      64'(nq.size()));
    checkOutput({tag, " n_ready"}, 64'(nInReady),  64'(nq.size() == 0 || nOutReady));
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic applyStimulus();
    bit sAcc, sCons, nAcc, nCons, fl;
    logic [W-1:0] sD, nD;
    sAcc  = sInValid && (sq.size() < 2);
    sCons = (sq.size() != 0) && sOutReady;
    nAcc  = nInValid && (nq.size() == 0 || nOutReady);
    nCons = (nq.size() != 0) && nOutReady;
    sD = sInData;
    nD = nInData;
    fl = flush;
    @(posedge clk);
    #1;
    if (fl) begin
      sq.delete();
      nq.delete();
    end else begin
      if (sCons) void'(sq.pop_front());
      if (sAcc)  sq.push_back(sD);
      if (nCons) void'(nq.pop_front());
      if (nAcc)  nq.push_back(nD);
    end
  endtask

  task automatic idleInputs();
    flush = 0;
    sInValid = 0; sOutReady = 0; sInData = '0;
    nInValid = 0; nOutReady = 0; nInData = '0;
  endtask

  initial begin
    logic [W-1:0] streamVals [3];
    streamVals[0] = 16'h1111;
    streamVals[1] = 16'h2222;
    streamVals[2] = 16'h3333;

    idleInputs();
    rst_n = 0;
    #1;
    checkAll("reset");
    #12 rst_n = 1;
    applyStimulus();
    checkAll("post reset");

    // Streaming through the skid instance at full rate.
    sOutReady = 1;
    for (int i = 0; i < 3; i++) begin
      sInValid = 1;
      sInData  = streamVals[i];
      #1;
      applyStimulus();
      checkOutput("stream data", 64'(sOutData), 64'(streamVals[i]));
      checkOutput("stream valid", 64'(sOutValid), 64'd1);
      checkOutput("stream occ", 64'(sOcc), 64'd1);
    end
    sInValid = 0;
    applyStimulus();
    checkAll("stream drain");

    // Backpressure fills both entries and holds the head stable.
    sOutReady = 0;
    sInValid = 1; sInData = 16'h000A; applyStimulus();
    sInData = 16'h000B; applyStimulus();
    sInValid = 0; #1;
    checkOutput("bp occ", 64'(sOcc), 64'd2);
    checkOutput("bp ready", 64'(sInReady), 64'd0);
    checkOutput("bp head", 64'(sOutData), 64'hA);
    applyStimulus();
    checkOutput("bp stable", 64'(sOutData), 64'hA);
    sOutReady = 1; applyStimulus();
    checkOutput("bp second", 64'(sOutData), 64'hB);
    checkAll("bp one left");
    applyStimulus();
    checkOutput("bp empty", 64'(sOcc), 64'd0);

    // Flush while full, colliding with an incoming payload.
    sOutReady = 0;
    sInValid = 1; sInData = 16'h00A2; applyStimulus();
    sInData = 16'h00B2; applyStimulus();
    checkOutput("pre flush occ", 64'(sOcc), 64'd2);
    flush = 1; sInData = 16'h000C; applyStimulus();
    checkOutput("flush valid", 64'(sOutValid), 64'd0);
    checkOutput("flush data", 64'(sOutData), 64'd0);
    checkOutput("flush occ", 64'(sOcc), 64'd0);
    flush = 0; sInValid = 0; sOutReady = 1; applyStimulus();
    checkOutput("no C valid", 64'(sOutValid), 64'd0);
    checkAll("after flush");

    // Non-skid: ready follows out_ready combinationally while full.
    nOutReady = 0;
    nInValid = 1; nInData = 16'h0005; applyStimulus();
    nInData = 16'h0006; #1;
    checkOutput("comb ready low", 64'(nInReady), 64'd0);
    nOutReady = 1; #1;
    checkOutput("comb ready high", 64'(nInReady), 64'd1);
    applyStimulus();
    checkOutput("comb replace", 64'(nOutData), 64'h6);
    checkOutput("comb occ", 64'(nOcc), 64'd1);
    nInValid = 0; applyStimulus();
    checkAll("comb drain");

    // Asynchronous reset mid-stream, with flush asserted as well.
    sOutReady = 0; nOutReady = 0;
    sInValid = 1; nInValid = 1;
    sInData = 16'h0DD1; nInData = 16'h0EE1; applyStimulus();
    sInData = 16'h0DD2; applyStimulus();
    sInValid = 0; nInValid = 0; #1;
    checkOutput("pre reset s_occ", 64'(sOcc), 64'd2);
    checkOutput("pre reset n_occ", 64'(nOcc), 64'd1);
    rst_n = 0; flush = 1;
    #1;
    sq.delete(); nq.delete();
    checkOutput("async s_valid", 64'(sOutValid), 64'd0);
    checkOutput("async s_data", 64'(sOutData), 64'd0);
    checkOutput("async s_occ", 64'(sOcc), 64'd0);
    checkOutput("async s_ready", 64'(sInReady), 64'd1);
    checkOutput("async n_valid", 64'(nOutValid), 64'd0);
    checkOutput("async n_data", 64'(nOutData), 64'd0);
    checkOutput("async n_occ", 64'(nOcc), 64'd0);
    checkOutput("async n_ready", 64'(nInReady), 64'd1);
    #2 rst_n = 1; flush = 0;
    applyStimulus();
    checkAll("after async reset");

    // Random soak against the queue model.
    for (int i = 0; i < 10000; i++) begin
      sInValid  = ($urandom_range(0, 3) != 0);
      sOutReady = ($urandom_range(0, 2) != 0);
      sInData   = W'($urandom);
      nInValid  = ($urandom_range(0, 3) != 0);
      nOutReady = ($urandom_range(0, 2) != 0);
      nInData   = W'($urandom);
      flush     = ($urandom_range(0, 63) == 0);
      #1;
      checkAll("soak");
      applyStimulus();
    end
    idleInputs();
    #1;
    checkAll("soak end");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
